// File: rtl/pipe_stage_buffer_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_buffer_if
// Valid/ready handshake bundle carrying one pipeline entry: multi-channel
// data plus a control bundle.
//   data  : NUM_CH*DATA_W flattened channels (channel k at [k*DATA_W +: DATA_W])
//   ctrl  : CTRL_W control bundle travelling with the data
//   valid : producer holds a valid entry
//   ready : consumer can take the entry
// Modports:
//   master : producer side (drives data/ctrl/valid, samples ready)
//   slave  : consumer side (samples data/ctrl/valid, drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_buffer_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CTRL_W = 8
);
    logic [NUM_CH*DATA_W-1:0] data;
    logic [CTRL_W-1:0]        ctrl;
    logic                     valid;
    logic                     ready;

    modport master (output data, output ctrl, output valid, input ready);
    modport slave  (input data, input ctrl, input valid, output ready);
endinterface

// File: rtl/pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// pipe_stage_buffer
// Registered pipeline stage with a one-entry skid buffer. The main register
// drives the downstream outputs directly; the skid register catches the one
// entry that arrives while downstream is stalling, so ready towards upstream
// is decoded purely from state (no combinational path from downstream ready).
//
// Ports:
//   clk            : sole clock, rising edge
//   rst            : asynchronous active-high reset
//   up  (slave)    : upstream bus; up.data/up.ctrl/up.valid in, up.ready out
//   dn  (master)   : downstream bus; dn.data/dn.ctrl/dn.valid out, dn.ready in
//   flush_in       : synchronous kill of all held entries (overrides all)
//   stall_cnt_out  : saturating count of cycles with dn.valid=1, dn.ready=0
//   bubble_cnt_out : saturating count of cycles with dn.valid=0
//
// Build option:
//   PIPE_STAGE_STATS_EN - when defined, the stall/bubble counters exist;
//   otherwise both counter outputs are constant zero with no flops.
// ---------------------------------------------------------------------------
module pipe_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_buffer_if.slave   up,
    pipe_stage_buffer_if.master  dn,
    input  logic                 flush_in,
    output logic [CNT_W-1:0]     stall_cnt_out,
    output logic [CNT_W-1:0]     bubble_cnt_out
);

    localparam int BUS_W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [BUS_W-1:0]    main_data_reg, main_data_next;
    logic [CTRL_W-1:0]   main_ctrl_reg, main_ctrl_next;
    logic [BUS_W-1:0]    skid_data_reg, skid_data_next;
    logic [CTRL_W-1:0]   skid_ctrl_reg, skid_ctrl_next;

    logic ready_int;
    logic valid_int;
    logic accept;

    assign ready_int = (state_reg != TWO);
    assign valid_int = (state_reg != EMPTY);
    assign accept    = up.valid && ready_int;

    // State and storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            main_data_reg <= '0;
            main_ctrl_reg <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_data_reg <= main_data_next;
            main_ctrl_reg <= main_ctrl_next;
            skid_data_reg <= skid_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
        end
    end

    // Next-state and storage update
    always_comb begin
        state_next     = state_reg;
        main_data_next = main_data_reg;
        main_ctrl_next = main_ctrl_reg;
        skid_data_next = skid_data_reg;
        skid_ctrl_next = skid_ctrl_reg;

        if (flush_in) begin
            // Flush wins: drop everything held and any same-cycle accept.
            // Payload registers keep their contents; they are invisible
            // once the state is EMPTY.
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        main_data_next = up.data;
                        main_ctrl_next = up.ctrl;
                        state_next     = ONE;
                    end
                end
                ONE: begin
                    if (accept && dn.ready) begin
                        main_data_next = up.data;
                        main_ctrl_next = up.ctrl;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind main.
                        skid_data_next = up.data;
                        skid_ctrl_next = up.ctrl;
                        state_next     = TWO;
                    end else if (dn.ready) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (dn.ready) begin
                        main_data_next = skid_data_reg;
                        main_ctrl_next = skid_ctrl_reg;
                        state_next     = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Outputs come straight from the main register; control is zeroed on
    // bubbles so a stale write enable can never reach the next stage.
    assign up.ready = ready_int;
    assign dn.valid = valid_int;
    assign dn.data  = main_data_reg;
    assign dn.ctrl  = valid_int ? main_ctrl_reg : '0;

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] bubble_cnt_reg;

    // Counters look at the outputs as they stood before the edge, so a
    // flush cycle is classified by what downstream saw during that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (valid_int && !dn.ready && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (!valid_int && (bubble_cnt_reg != CNT_MAX)) begin
                bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cnt_out  = stall_cnt_reg;
    assign bubble_cnt_out = bubble_cnt_reg;
`else
    assign stall_cnt_out  = '0;
    assign bubble_cnt_out = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buffer
// Directed, table-driven bench for pipe_stage_buffer. Each table row gives
// the inputs for one clock cycle and the outputs expected just after that
// edge. Hand-written sequences cover asynchronous reset and the counters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int BUS_W  = NUM_CH * DATA_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_in = 1'b0;
    logic [CNT_W-1:0] stall_cnt_out;
    logic [CNT_W-1:0] bubble_cnt_out;

    pipe_stage_buffer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W)) up_if ();
    pipe_stage_buffer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CTRL_W(CTRL_W)) dn_if ();

    pipe_stage_buffer #(
        .DATA_W(DATA_W),
        .NUM_CH(NUM_CH),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .up            (up_if),
        .dn            (dn_if),
        .flush_in      (flush_in),
        .stall_cnt_out (stall_cnt_out),
        .bubble_cnt_out(bubble_cnt_out)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       v;
        logic       r;
        logic       f;
        logic [7:0] d;
        logic [7:0] c;
        logic       ev;
        logic       er;
        logic [7:0] ed;
        logic [7:0] ec;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    // Channel k carries {16'h0, k, d} so a channel swap shows up.
    function automatic logic [BUS_W-1:0] pack(input logic [7:0] d);
        logic [BUS_W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            res[k*DATA_W +: DATA_W] = {16'h0, 8'(k), d};
        end
        return res;
    endfunction

    function automatic vec_t mk(input logic v, input logic r, input logic f,
                                input logic [7:0] d, input logic [7:0] c,
                                input logic ev, input logic er,
                                input logic [7:0] ed, input logic [7:0] ec);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.d = d; t.c = c;
        t.ev = ev; t.er = er; t.ed = ed; t.ec = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [BUS_W-1:0] act,
                         input logic [BUS_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic f,
                         input logic [7:0] d, input logic [7:0] c);
        up_if.valid = v;
        up_if.data  = pack(d);
        up_if.ctrl  = c;
        dn_if.ready = r;
        flush_in    = f;
    endtask

    // Apply inputs, let one rising edge pass, return 1 unit after it.
    task automatic step(input logic v, input logic r, input logic f,
                        input logic [7:0] d, input logic [7:0] c);
        drive(v, r, f, d, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              v  r  f  d      c      ev er ed     ec
        // streaming
        vecs[0]  = mk(1, 1, 0, 8'h01, 8'h11, 1, 1, 8'h01, 8'h11);
        vecs[1]  = mk(1, 1, 0, 8'h02, 8'h12, 1, 1, 8'h02, 8'h12);
        vecs[2]  = mk(1, 1, 0, 8'h03, 8'h13, 1, 1, 8'h03, 8'h13);
        vecs[3]  = mk(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
        // backpressure: A, B go in, C waits upstream
        vecs[4]  = mk(1, 0, 0, 8'h0A, 8'h21, 1, 1, 8'h0A, 8'h21);
        vecs[5]  = mk(1, 0, 0, 8'h0B, 8'h22, 1, 0, 8'h0A, 8'h21);
        vecs[6]  = mk(1, 0, 0, 8'h0C, 8'h23, 1, 0, 8'h0A, 8'h21);
        vecs[7]  = mk(1, 1, 0, 8'h0C, 8'h23, 1, 1, 8'h0B, 8'h22);
        vecs[8]  = mk(1, 1, 0, 8'h0C, 8'h23, 1, 1, 8'h0C, 8'h23);
        vecs[9]  = mk(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
        // flush while TWO with a same-cycle 0xD offer
        vecs[10] = mk(1, 0, 0, 8'h04, 8'h31, 1, 1, 8'h04, 8'h31);
        vecs[11] = mk(1, 0, 0, 8'h05, 8'h32, 1, 0, 8'h04, 8'h31);
        vecs[12] = mk(1, 0, 1, 8'h0D, 8'h33, 0, 1, 8'h00, 8'h00);
        vecs[13] = mk(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
        // bubble gating of ctrl
        vecs[14] = mk(1, 1, 0, 8'h06, 8'hFF, 1, 1, 8'h06, 8'hFF);
        vecs[15] = mk(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);
        // flush in ONE with accept and downstream ready
        vecs[16] = mk(1, 0, 0, 8'h07, 8'h41, 1, 1, 8'h07, 8'h41);
        vecs[17] = mk(1, 1, 1, 8'h08, 8'h42, 0, 1, 8'h00, 8'h00);
        // ONE holding under stall, then drain
        vecs[18] = mk(1, 0, 0, 8'h09, 8'h51, 1, 1, 8'h09, 8'h51);
        vecs[19] = mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h09, 8'h51);
        vecs[20] = mk(0, 1, 0, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00);

        drive(0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;

        // ---- reset state ----
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset valid_out", BUS_W'(dn_if.valid), BUS_W'(1'b0));
        check("reset ready_out", BUS_W'(up_if.ready), BUS_W'(1'b1));
        check("reset ctrl_out", BUS_W'(dn_if.ctrl), '0);
        check("reset data_out", dn_if.data, '0);
        check("reset stall_cnt", BUS_W'(stall_cnt_out), '0);
        check("reset bubble_cnt", BUS_W'(bubble_cnt_out), '0);
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].d, vecs[i].c);
            $display("[TB] vec %0d v=%0b r=%0b f=%0b d=%0h -> valid=%0b ready=%0b ctrl=%0h",
                     i, vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].d,
                     dn_if.valid, up_if.ready, dn_if.ctrl);
            check($sformatf("vec%0d valid_out", i), BUS_W'(dn_if.valid), BUS_W'(vecs[i].ev));
            check($sformatf("vec%0d ready_out", i), BUS_W'(up_if.ready), BUS_W'(vecs[i].er));
            check($sformatf("vec%0d ctrl_out", i), BUS_W'(dn_if.ctrl), BUS_W'(vecs[i].ec));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d data_out", i), dn_if.data, pack(vecs[i].ed));
            end
        end

        // ---- asynchronous reset while in TWO ----
        step(1, 0, 0, 8'h61, 8'h71);
        step(1, 0, 0, 8'h62, 8'h72);
        check("pre-reset ready_out (TWO)", BUS_W'(up_if.ready), BUS_W'(1'b0));
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] async reset mid-cycle -> valid=%0b ready=%0b", dn_if.valid, up_if.ready);
        check("async reset valid_out", BUS_W'(dn_if.valid), BUS_W'(1'b0));
        check("async reset ready_out", BUS_W'(up_if.ready), BUS_W'(1'b1));
        check("async reset ctrl_out", BUS_W'(dn_if.ctrl), '0);
        check("async reset data_out", dn_if.data, '0);
        // release before the next edge; that edge must accept
        rst = 1'b0;
        step(1, 1, 0, 8'h63, 8'h73);
        $display("[TB] first accept after reset -> valid=%0b ctrl=%0h", dn_if.valid, dn_if.ctrl);
        check("first accept valid_out", BUS_W'(dn_if.valid), BUS_W'(1'b1));
        check("first accept data_out", dn_if.data, pack(8'h63));
        check("first accept ctrl_out", BUS_W'(dn_if.ctrl), BUS_W'(8'h73));
        // the skid entry 0x62 must be gone: draining gives nothing more
        step(0, 1, 0, 8'h00, 8'h00);
        check("post-reset drain valid_out", BUS_W'(dn_if.valid), BUS_W'(1'b0));

        // ---- statistics ----
        drive(0, 0, 0, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 8'h00);
        step(1, 0, 0, 8'h0E, 8'h0E);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 8'h00, 8'h00);
        $display("[TB] stats after 14 stall cycles -> stall=%0d bubble=%0d",
                 stall_cnt_out, bubble_cnt_out);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_cnt at 14", BUS_W'(stall_cnt_out), BUS_W'(14));
        check("bubble_cnt at 4", BUS_W'(bubble_cnt_out), BUS_W'(4));
`else
        check("stall_cnt tied 0", BUS_W'(stall_cnt_out), '0);
        check("bubble_cnt tied 0", BUS_W'(bubble_cnt_out), '0);
`endif
        for (int i = 0; i < 6; i++) step(0, 0, 0, 8'h00, 8'h00);
        $display("[TB] stats after 20 stall cycles -> stall=%0d bubble=%0d",
                 stall_cnt_out, bubble_cnt_out);
`ifdef PIPE_STAGE_STATS_EN
        check("stall_cnt saturated", BUS_W'(stall_cnt_out), BUS_W'(15));
        check("bubble_cnt held", BUS_W'(bubble_cnt_out), BUS_W'(4));
`else
        check("stall_cnt tied 0 later", BUS_W'(stall_cnt_out), '0);
        check("bubble_cnt tied 0 later", BUS_W'(bubble_cnt_out), '0);
`endif
        check("stats held entry", dn_if.data, pack(8'h0E));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
